// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM states, IF/ID payload, PC width and NOP encoding.
package fetch_unit_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [INSN_W-1:0] instr;
        logic [PC_W-1:0]   pc_plus4;
    } if_id_t;

    // Instruction addresses are word aligned; the low two bits never reach the PC.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with write enable and synchronous flush to a bubble.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // A bubble clears valid and instr but leaves pc_plus4 as it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP;
        end else if (we) begin
            if (d.valid) begin
                q <= d;
            end else begin
                q.valid <= 1'b0;
                q.instr <= NOP;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request handshake, one-entry hold buffer, IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en_f,
    input  logic              if_id_wr,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   pc_f,
    output logic [INSN_W-1:0] instr_d,
    output logic [PC_W-1:0]   pc_plus4_d,
    output logic              valid_d
);

    fetch_state_t      state;
    logic [PC_W-1:0]   pc_q;
    logic              hold_valid;
    logic [INSN_W-1:0] hold_instr;
    logic [PC_W-1:0]   hold_pc4;
    logic              accept;
    logic              resp_take;
    if_id_t            if_id_d;
    if_id_t            if_id_q;

    always_comb begin
        imem_req = 1'b0;
        if (!rst && state == IDLE && pc_en_f && !redirect && !hold_valid) begin
            imem_req = 1'b1;
        end
    end

    assign accept    = imem_req & imem_ready;
    assign resp_take = (state == WAIT) && imem_rvalid && !redirect;

    // While WAIT the PC has already advanced past the outstanding fetch, so pc_q is its PC+4.
    always_comb begin
        if_id_d = '0;
        if (hold_valid) begin
            if_id_d.valid    = 1'b1;
            if_id_d.instr    = hold_instr;
            if_id_d.pc_plus4 = hold_pc4;
        end else if (resp_take) begin
            if_id_d.valid    = 1'b1;
            if_id_d.instr    = imem_rdata;
            if_id_d.pc_plus4 = pc_q;
        end
    end

    // A response that lands together with a redirect retires the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state <= WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= align_pc(RESET_PC);
        end else if (redirect) begin
            pc_q <= align_pc(redirect_pc);
        end else if (accept) begin
            pc_q <= PC_W'(pc_q + PC_W'(4));
        end
    end

    // Hold buffer catches a response that arrives while IF/ID is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP;
            hold_pc4   <= '0;
        end else if (redirect) begin
            hold_valid <= 1'b0;
        end else if (resp_take && !if_id_wr) begin
            hold_valid <= 1'b1;
            hold_instr <= imem_rdata;
            hold_pc4   <= pc_q;
        end else if (if_id_wr) begin
            hold_valid <= 1'b0;
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .we    (if_id_wr),
        .flush (redirect),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign imem_addr  = pc_q;
    assign pc_f       = pc_q;
    assign instr_d    = if_id_q.instr;
    assign pc_plus4_d = if_id_q.pc_plus4;
    assign valid_d    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall buffering, redirect/drop, PC wrap, mid-flight reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en_f;
    logic        if_id_wr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int checks = 0;
    int errors = 0;
    logic auto_mem = 1'b1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en_f     (pc_en_f),
        .if_id_wr    (if_id_wr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    // One clock; in auto mode the memory answers an accepted request on the next cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req & imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? word(a) : 32'h0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_en_f = 1'b1; if_id_wr = 1'b1; redirect = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
        checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", pc_f); end
        checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
            errors++; $display("FAIL reset_ifid got v=%0b i=%h p=%h want 0/0/0", valid_d, instr_d, pc_plus4_d); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 32'(k * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin
                errors++; $display("FAIL seq_req%0d got req=%0b addr=%h want 1 %h", k, imem_req, imem_addr, a); end
            tick();
            checks++; if (imem_req !== 1'b0 || valid_d !== 1'b0) begin
                errors++; $display("FAIL seq_wait%0d got req=%0b v=%0b want 0 0", k, imem_req, valid_d); end
            tick();
            checks++; if (valid_d !== 1'b1 || instr_d !== word(a) || pc_plus4_d !== 32'(a + 4)) begin
                errors++; $display("FAIL seq_out%0d got v=%0b i=%h p=%h want 1 %h %h", k, valid_d, instr_d, pc_plus4_d, word(a), 32'(a + 4)); end
        end
    endtask

    task automatic test_stall();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr got %h want 00000008", imem_addr); end
        tick();
        pc_en_f = 1'b0; if_id_wr = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || valid_d !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got req=%0b v=%0b want 0 0", k, imem_req, valid_d); end
        end
        pc_en_f = 1'b1; if_id_wr = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_bufblock got %0b want 0", imem_req); end
        tick();
        checks++; if (valid_d !== 1'b1 || instr_d !== word(32'h8) || pc_plus4_d !== 32'hC) begin
            errors++; $display("FAIL stall_drain got v=%0b i=%h p=%h want 1 %h 0000000c", valid_d, instr_d, pc_plus4_d, word(32'h8)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++; $display("FAIL stall_next got req=%0b addr=%h want 1 0000000c", imem_req, imem_addr); end
        tick();
        checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL stall_nodup got %0b want 0", valid_d); end
        tick();
        checks++; if (valid_d !== 1'b1 || instr_d !== word(32'hC) || pc_plus4_d !== 32'h10) begin
            errors++; $display("FAIL stall_after got v=%0b i=%h p=%h want 1 %h 00000010", valid_d, instr_d, pc_plus4_d, word(32'hC)); end
    endtask

    task automatic test_redirect_drop();
        auto_mem = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL redir_pre got req=%0b addr=%h want 1 00000010", imem_req, imem_addr); end
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noreq got %0b want 0", imem_req); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (pc_f !== 32'h100 || valid_d !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_drop got pc=%h v=%0b req=%0b want 00000100 0 0", pc_f, valid_d, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0010;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        checks++; if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_discard got v=%0b req=%0b addr=%h want 0 1 00000100", valid_d, imem_req, imem_addr); end
        auto_mem = 1'b1;
        tick();
        tick();
        checks++; if (valid_d !== 1'b1 || instr_d !== word(32'h100) || pc_plus4_d !== 32'h104) begin
            errors++; $display("FAIL redir_target got v=%0b i=%h p=%h want 1 %h 00000104", valid_d, instr_d, pc_plus4_d, word(32'h100)); end
    endtask

    task automatic test_redirect_over_stall();
        if_id_wr = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstall_noreq got %0b want 0", imem_req); end
        tick();
        redirect = 1'b0; if_id_wr = 1'b1;
        #1;
        checks++; if (valid_d !== 1'b0 || instr_d !== 32'h0 || pc_f !== 32'h200 || pc_plus4_d !== 32'h104) begin
            errors++; $display("FAIL rstall_bubble got v=%0b i=%h pc=%h p=%h want 0 00000000 00000200 00000104", valid_d, instr_d, pc_f, pc_plus4_d); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_req got req=%0b addr=%h want 1 fffffffc", imem_req, imem_addr); end
        tick();
        checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 00000000", pc_f); end
        tick();
        checks++; if (valid_d !== 1'b1 || instr_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0) begin
            errors++; $display("FAIL wrap_ifid got v=%0b i=%h p=%h want 1 fffffffc 00000000", valid_d, instr_d, pc_plus4_d); end
    endtask

    task automatic test_reset_midflight();
        auto_mem = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tick();
        checks++; if (imem_req !== 1'b0 || pc_f !== 32'h0 || valid_d !== 1'b0) begin
            errors++; $display("FAIL mrst_cycle got req=%0b pc=%h v=%0b want 0 00000000 0", imem_req, pc_f, valid_d); end
        rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
        #1;
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++; if (valid_d !== 1'b0 || pc_f !== 32'h0) begin
            errors++; $display("FAIL mrst_ignore got v=%0b pc=%h want 0 00000000", valid_d, pc_f); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL mrst_idle got req=%0b addr=%h want 1 00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_redirect_over_stall();
        test_wrap();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the five-stage pipeline. Owns the PC register, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register. It is the consumer of the load-use stall signals from the hazard unit (PC enable, IF/ID write enable) and of branch/jump redirects resolved in ID.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1: pipeline clock; all state updates on rising edge.
- rst  in  1: reset, synchronous, active-high.
- pc_en_f  in  1: from hazard unit; 0 = hold PC, issue no new fetch.
- if_id_wr  in  1: from hazard unit; 0 = hold IF/ID contents.
- redirect  in  1: taken branch/jump resolved in ID this cycle.
- redirect_pc  in  32: target PC, valid when redirect=1.
- imem_req  out  1: fetch request.
- imem_addr  out  32: word address of request (always pc_f).
- imem_ready  in  1: memory accepts request this cycle when imem_req=1.
- imem_rvalid  in  1: response valid; at most one outstanding request.
- imem_rdata  in  32: instruction word, valid with imem_rvalid.
- pc_f  out  32: current fetch PC.
- instr_d  out  32: IF/ID instruction.
- pc_plus4_d  out  32: IF/ID PC+4 of instr_d.
- valid_d  out  1: IF/ID holds a real instruction (0 = bubble, instr_d=0 NOP).

## Operation
- Fetch FSM states: IDLE (no request outstanding), WAIT (one outstanding, result wanted), DROP (one outstanding, result to be discarded).
- imem_req=1 only in IDLE, with pc_en_f=1, redirect=0, hold buffer empty; combinational from these.
- Accept = imem_req & imem_ready: pc_f <= pc_f+4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0), IDLE->WAIT.
- WAIT & imem_rvalid: word+its PC go to IF/ID directly if if_id_wr=1, else into hold buffer; WAIT->IDLE.
- IF/ID update when if_id_wr=1: source priority = hold buffer, then same-cycle response, else bubble (valid_d=0, instr_d=0, pc_plus4_d unchanged). Buffer drains on that update.
- if_id_wr=0: IF/ID unchanged; valid_d unchanged.
- redirect=1 (overrides stall and all else): pc_f <= redirect_pc; hold buffer cleared; IF/ID <= bubble next cycle; WAIT->DROP; any response arriving same cycle discarded; no request issued this cycle.
- DROP & imem_rvalid: data discarded, DROP->IDLE. Redirect while in DROP stays in DROP.
- redirect_pc[1:0] ignored; pc_f always word aligned (low bits forced 0).
- Response in IDLE is a protocol violation; ignored.

## Timing
- Reset values: pc_f=RESET_PC, state IDLE, buffer empty, instr_d=0, pc_plus4_d=0, valid_d=0, imem_req=0 in reset cycle.
- Memory latency >=1 cycle: imem_rvalid no earlier than cycle after accept.
- Best-case throughput with 1-cycle memory: one instruction per 2 cycles (issue, response); instr visible at valid_d the cycle after imem_rvalid.
- Redirect in cycle N: pc_f=redirect_pc and valid_d=0 in N+1; first fetch to target issued N+1 if IDLE, else after dropped response returns.
- rst in mid-transaction: state IDLE immediately; an in-flight response arriving after reset is ignored (IDLE rule).
- Stall (pc_en_f=0) never cancels an outstanding request; its result is buffered.

## Structure
- Shared pipeline package: fetch FSM state enum (IDLE/WAIT/DROP), NOP encoding 32'h0000_0000, PC width constant 32.
- One sub-module natural: if_id_reg (IF/ID register with write-enable and synchronous flush-to-bubble), reused style for ID/EX.
- Hold buffer and FSM inline in fetch_unit.

## Test plan
- Reset, then memory 1-cycle latency returning addr-derived words -> imem_addr 0,4,8..., valid_d pulses with pc_plus4_d 4,8,12 in order.
- Hold pc_en_f=if_id_wr=0 for 3 cycles while request at 0x8 outstanding -> response buffered, no new imem_req, then instr for 0x8 appears first cycle stall drops, no loss or duplication.
- Redirect to 0x100 while WAIT on 0x10 -> response for 0x10 dropped, valid_d=0 next cycle, next imem_addr 0x100.
- Redirect and if_id_wr=0 in same cycle -> redirect wins: IF/ID bubble, pc_f=target.
- PC at 32'hFFFF_FFFC accepted -> pc_f wraps to 0.
- Assert rst during WAIT, rvalid arrives next cycle -> ignored, pc_f=RESET_PC, valid_d=0.
